// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared TileLink-UH definitions for the host arbiter slice:
//   - A-channel and D-channel opcode encodings
//   - beat geometry for the fixed 64-bit (8-byte) data path
//   - tl_beats(): number of data beats a message of a given size occupies
// ---------------------------------------------------------------------------
package tl_pkg;

    // A-channel opcodes used by the hosts.
    typedef enum logic [2:0] {
        GET     = 3'd0,
        PUTFULL = 3'd1,
        PUTPART = 3'd2
    } tl_a_op_e;

    // D-channel opcodes returned by the SRAM controller.
    typedef enum logic [2:0] {
        ACK     = 3'd0,
        ACKDATA = 3'd1
    } tl_d_op_e;

    // log2 of the beat size in bytes (64-bit data path).
    localparam logic [2:0] TL_BEAT_LOG2 = 3'd3;

    // Beats occupied by a data-carrying message of 2^size bytes.
    // Anything that fits in one 8-byte beat takes a single beat.
    function automatic logic [4:0] tl_beats(input logic [2:0] size);
        if (size <= TL_BEAT_LOG2) begin
            return 5'd1;
        end
        return 5'd1 << (size - TL_BEAT_LOG2);
    endfunction

endpackage

// File: rtl/tl_burst_cnt.sv
// ---------------------------------------------------------------------------
// tl_burst_cnt
// Loadable 4-bit down-counter tracking the remaining beats of a burst.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   i_load         load i_load_val (takes priority over i_dec)
//   i_load_val     beats remaining after the current beat
//   i_dec          one continuation beat accepted
//   o_busy         a burst is in progress (count != 0)
//   o_last         the next accepted continuation beat is the final one
// ---------------------------------------------------------------------------
module tl_burst_cnt (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_busy,
    output logic       o_last
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_busy = (r_cnt != 4'd0);
    assign o_last = (r_cnt == 4'd1);

endmodule

// File: rtl/tl_host_arb2.sv
// ---------------------------------------------------------------------------
// tl_host_arb2
// Two-host TileLink-UH arbiter in front of the SRAM controller.
//   - Round-robin merge of both hosts' A channels onto one downstream A
//     channel; a multi-beat Put holds the grant until its last beat.
//   - The downstream source is {host index, host source}; D responses are
//     steered back by the top source bit and the tag is stripped.
//   - Each host may have at most MAX_OUTSTANDING transactions in flight.
//   - Fully combinational A and D paths; only arbitration and counting
//     state is registered.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   h_a_*                           per-host A channels, packed {h1,h0}
//   h_d_valid / h_d_ready           per-host D handshake
//   h_d_* (other)                   D fields broadcast to both hosts
//   m_a_*                           merged downstream A channel
//   m_d_*                           downstream D channel
// ---------------------------------------------------------------------------
module tl_host_arb2 #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int SOURCE_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic [1:0]                    h_a_valid,
    output logic [1:0]                    h_a_ready,
    input  logic [5:0]                    h_a_opcode,
    input  logic [5:0]                    h_a_param,
    input  logic [5:0]                    h_a_size,
    input  logic [2*(SOURCE_WIDTH-1)-1:0] h_a_source,
    input  logic [2*ADDR_WIDTH-1:0]       h_a_address,
    input  logic [2*DATA_WIDTH-1:0]       h_a_data,
    input  logic [2*(DATA_WIDTH/8)-1:0]   h_a_mask,

    output logic [1:0]                    h_d_valid,
    input  logic [1:0]                    h_d_ready,
    output logic [2:0]                    h_d_opcode,
    output logic [2:0]                    h_d_param,
    output logic [2:0]                    h_d_size,
    output logic [SOURCE_WIDTH-2:0]       h_d_source,
    output logic [DATA_WIDTH-1:0]         h_d_data,
    output logic                          h_d_corrupt,

    output logic                          m_a_valid,
    input  logic                          m_a_ready,
    output logic [2:0]                    m_a_opcode,
    output logic [2:0]                    m_a_param,
    output logic [2:0]                    m_a_size,
    output logic [SOURCE_WIDTH-1:0]       m_a_source,
    output logic [ADDR_WIDTH-1:0]         m_a_address,
    output logic [DATA_WIDTH-1:0]         m_a_data,
    output logic [DATA_WIDTH/8-1:0]       m_a_mask,

    input  logic                          m_d_valid,
    output logic                          m_d_ready,
    input  logic [2:0]                    m_d_opcode,
    input  logic [2:0]                    m_d_param,
    input  logic [2:0]                    m_d_size,
    input  logic [SOURCE_WIDTH-1:0]       m_d_source,
    input  logic [DATA_WIDTH-1:0]         m_d_data,
    input  logic                          m_d_corrupt
);

    import tl_pkg::*;

    localparam int         HSW     = SOURCE_WIDTH - 1;
    localparam int         MW      = DATA_WIDTH / 8;
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    // Registered arbitration / accounting state.
    logic             r_lock_host;
    logic             r_last_grant;
    logic [1:0][3:0]  r_out_cnt;

    // A-side wires.
    logic [1:0] w_elig;
    logic       w_lock;
    logic       w_a_last;
    logic       w_grant;
    logic       w_m_valid;
    logic       w_a_acc;
    logic       w_hdr_acc;
    logic       w_a_burst;
    logic [3:0] w_a_load_val;

    // D-side wires.
    logic       w_d_idx;
    logic       w_d_rdy;
    logic       w_d_acc;
    logic       w_d_busy;
    logic       w_d_cnt_last;
    logic       w_d_burst;
    logic       w_d_last;
    logic [3:0] w_d_load_val;

    logic [1:0] w_out_inc;
    logic [1:0] w_out_dec;

    // ------------------------------------------------------------------
    // A arbitration
    // ------------------------------------------------------------------
    assign w_elig[0] = h_a_valid[0] && (r_out_cnt[0] < MAX_OUT);
    assign w_elig[1] = h_a_valid[1] && (r_out_cnt[1] < MAX_OUT);

    // When neither host is eligible the grant still points somewhere so
    // the payload mux is defined; m_a_valid is 0 in that case.
    always_comb begin
        w_grant = ~r_last_grant;
        if (w_lock) begin
            w_grant = r_lock_host;
        end else if (w_elig == 2'b01) begin
            w_grant = 1'b0;
        end else if (w_elig == 2'b10) begin
            w_grant = 1'b1;
        end
    end

    // Continuation beats of a locked Put bypass the outstanding limit.
    assign w_m_valid = w_lock ? h_a_valid[w_grant] : w_elig[w_grant];

    assign m_a_valid   = w_m_valid;
    assign m_a_opcode  = w_grant ? h_a_opcode[5:3] : h_a_opcode[2:0];
    assign m_a_param   = w_grant ? h_a_param[5:3]  : h_a_param[2:0];
    assign m_a_size    = w_grant ? h_a_size[5:3]   : h_a_size[2:0];
    assign m_a_source  = {w_grant, (w_grant ? h_a_source[2*HSW-1:HSW]
                                            : h_a_source[HSW-1:0])};
    assign m_a_address = w_grant ? h_a_address[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : h_a_address[ADDR_WIDTH-1:0];
    assign m_a_data    = w_grant ? h_a_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : h_a_data[DATA_WIDTH-1:0];
    assign m_a_mask    = w_grant ? h_a_mask[2*MW-1:MW] : h_a_mask[MW-1:0];

    // Ready is only offered to the host whose beat is actually presented,
    // so a stalled (over-limit) or idle host never sees ready.
    assign h_a_ready = (w_m_valid && m_a_ready) ? (w_grant ? 2'b10 : 2'b01)
                                                : 2'b00;

    assign w_a_acc   = w_m_valid && m_a_ready;
    assign w_hdr_acc = w_a_acc && !w_lock;

    // Gets carry no data on A, so only multi-beat Puts hold the channel.
    assign w_a_burst    = ((m_a_opcode == PUTFULL) || (m_a_opcode == PUTPART))
                          && (m_a_size > TL_BEAT_LOG2);
    assign w_a_load_val = 4'(tl_beats(m_a_size) - 5'd1);

    tl_burst_cnt u_a_burst (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_load     (w_hdr_acc && w_a_burst),
        .i_load_val (w_a_load_val),
        .i_dec      (w_a_acc && w_lock),
        .o_busy     (w_lock),
        .o_last     (w_a_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_grant <= 1'b1;
            r_lock_host  <= 1'b0;
        end else if (w_hdr_acc) begin
            r_last_grant <= w_grant;
            if (w_a_burst) begin
                r_lock_host <= w_grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // D routing
    // ------------------------------------------------------------------
    assign w_d_idx = m_d_source[SOURCE_WIDTH-1];
    assign w_d_rdy = h_d_ready[w_d_idx];
    assign w_d_acc = m_d_valid && w_d_rdy;

    assign h_d_valid   = m_d_valid ? (w_d_idx ? 2'b10 : 2'b01) : 2'b00;
    assign m_d_ready   = w_d_acc;
    assign h_d_opcode  = m_d_opcode;
    assign h_d_param   = m_d_param;
    assign h_d_size    = m_d_size;
    assign h_d_source  = m_d_source[SOURCE_WIDTH-2:0];
    assign h_d_data    = m_d_data;
    assign h_d_corrupt = m_d_corrupt;

    // First beat of a multi-beat AccessAckData loads the remaining count;
    // every response (corrupt or not) ends on exactly one last beat.
    assign w_d_burst    = (m_d_opcode == ACKDATA) && (m_d_size > TL_BEAT_LOG2);
    assign w_d_load_val = 4'(tl_beats(m_d_size) - 5'd1);
    assign w_d_last     = w_d_acc && (w_d_busy ? w_d_cnt_last : !w_d_burst);

    tl_burst_cnt u_d_burst (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_load     (w_d_acc && !w_d_busy && w_d_burst),
        .i_load_val (w_d_load_val),
        .i_dec      (w_d_acc && w_d_busy),
        .o_busy     (w_d_busy),
        .o_last     (w_d_cnt_last)
    );

    // ------------------------------------------------------------------
    // Outstanding accounting
    // ------------------------------------------------------------------
    assign w_out_inc = w_hdr_acc ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign w_out_dec = w_d_last  ? (w_d_idx ? 2'b10 : 2'b01) : 2'b00;

    // A request and a final response on the same host cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_out_inc[i] && !w_out_dec[i]) begin
                    r_out_cnt[i] <= r_out_cnt[i] + 4'd1;
                end else if (w_out_dec[i] && !w_out_inc[i]) begin
                    r_out_cnt[i] <= r_out_cnt[i] - 4'd1;
                end
            end
        end
    end

    // w_a_last is implied by the lock dropping; kept for symmetry.
    logic w_unused;
    assign w_unused = w_a_last;

endmodule

// File: tb/tb_tl_host_arb2.sv
module tb_tl_host_arb2;

    import tl_pkg::*;

    localparam int MAXO = 2;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [1:0]   h_a_valid, h_a_ready;
    logic [5:0]   h_a_opcode, h_a_param, h_a_size, h_a_source;
    logic [63:0]  h_a_address;
    logic [127:0] h_a_data;
    logic [15:0]  h_a_mask;
    logic [1:0]   h_d_valid, h_d_ready;
    logic [2:0]   h_d_opcode, h_d_param, h_d_size, h_d_source;
    logic [63:0]  h_d_data;
    logic         h_d_corrupt;
    logic         m_a_valid, m_a_ready;
    logic [2:0]   m_a_opcode, m_a_param, m_a_size;
    logic [3:0]   m_a_source;
    logic [31:0]  m_a_address;
    logic [63:0]  m_a_data;
    logic [7:0]   m_a_mask;
    logic         m_d_valid, m_d_ready;
    logic [2:0]   m_d_opcode, m_d_param, m_d_size;
    logic [3:0]   m_d_source;
    logic [63:0]  m_d_data;
    logic         m_d_corrupt;

    tl_host_arb2 #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .SOURCE_WIDTH(4), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .h_a_valid(h_a_valid), .h_a_ready(h_a_ready), .h_a_opcode(h_a_opcode),
        .h_a_param(h_a_param), .h_a_size(h_a_size), .h_a_source(h_a_source),
        .h_a_address(h_a_address), .h_a_data(h_a_data), .h_a_mask(h_a_mask),
        .h_d_valid(h_d_valid), .h_d_ready(h_d_ready), .h_d_opcode(h_d_opcode),
        .h_d_param(h_d_param), .h_d_size(h_d_size), .h_d_source(h_d_source),
        .h_d_data(h_d_data), .h_d_corrupt(h_d_corrupt),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
        .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
        .m_a_address(m_a_address), .m_a_data(m_a_data), .m_a_mask(m_a_mask),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
        .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source),
        .m_d_data(m_d_data), .m_d_corrupt(m_d_corrupt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: transaction-level bookkeeping with plain integers.
    int m_out[2];      // in-flight requests per host
    int m_burst;       // Put data beats still owed by the lock holder
    int m_lock_host;
    int m_last;        // host granted most recently
    int m_dleft;       // D beats still owed by the current response

    task automatic model_reset();
        m_out[0] = 0; m_out[1] = 0;
        m_burst = 0; m_lock_host = 0; m_last = 1; m_dleft = 0;
    endtask

    // Compare every output against the model, then advance the model as
    // the coming clock edge will.
    task automatic eval();
        int g, di;
        logic mv, dlast;
        logic [1:0] el;
        logic [2:0] op, sz;
        #1;
        if (!rst_ni) model_reset();
        if (m_burst > 0) begin
            g  = m_lock_host;
            mv = h_a_valid[g];
        end else begin
            el[0] = h_a_valid[0] && (m_out[0] < MAXO);
            el[1] = h_a_valid[1] && (m_out[1] < MAXO);
            if (el == 2'b11) g = 1 - m_last;
            else if (el[1])  g = 1;
            else             g = 0;
            mv = el[g];
        end
        op = h_a_opcode[g*3 +: 3];
        sz = h_a_size[g*3 +: 3];
        chk("m_a_valid", m_a_valid, mv);
        chk("h_a_ready", h_a_ready, (mv && m_a_ready) ? (2'b01 << g) : 2'b00);
        if (mv) begin
            chk("m_a_opcode", m_a_opcode, op);
            chk("m_a_size", m_a_size, sz);
            chk("m_a_param", m_a_param, h_a_param[g*3 +: 3]);
            chk("m_a_source", m_a_source, {1'(g), h_a_source[g*3 +: 3]});
            chk("m_a_address", m_a_address, h_a_address[g*32 +: 32]);
            chk("m_a_data", m_a_data, h_a_data[g*64 +: 64]);
            chk("m_a_mask", m_a_mask, h_a_mask[g*8 +: 8]);
        end
        di = int'(m_d_source[3]);
        chk("h_d_valid", h_d_valid, m_d_valid ? (2'b01 << di) : 2'b00);
        chk("m_d_ready", m_d_ready, m_d_valid && h_d_ready[di]);
        if (m_d_valid) begin
            chk("h_d_source", h_d_source, m_d_source[2:0]);
            chk("h_d_hdr", {h_d_opcode, h_d_param, h_d_size, h_d_corrupt},
                {m_d_opcode, m_d_param, m_d_size, m_d_corrupt});
            chk("h_d_data", h_d_data, m_d_data);
        end
        if (rst_ni) begin
            if (mv && m_a_ready) begin
                if (m_burst > 0) m_burst--;
                else begin
                    m_last = g;
                    m_out[g]++;
                    if ((op == 3'd1 || op == 3'd2) && sz > 3) begin
                        m_burst = (1 << (sz - 3)) - 1;
                        m_lock_host = g;
                    end
                end
            end
            if (m_d_valid && h_d_ready[di]) begin
                dlast = 1'b0;
                if (m_dleft > 0) begin
                    m_dleft--;
                    dlast = (m_dleft == 0);
                end else if (m_d_opcode == 3'd1 && m_d_size > 3) begin
                    m_dleft = (1 << (m_d_size - 3)) - 1;
                end else begin
                    dlast = 1'b1;
                end
                if (dlast) m_out[di]--;
            end
        end
    endtask

    task automatic tick();
        eval();
        @(negedge clk);
    endtask

    task automatic set_host(input int h, input logic v, input logic [2:0] op,
                            input logic [2:0] sz, input logic [2:0] src);
        h_a_valid[h]          = v;
        h_a_opcode[h*3 +: 3]  = op;
        h_a_size[h*3 +: 3]    = sz;
        h_a_source[h*3 +: 3]  = src;
        h_a_param[h*3 +: 3]   = 3'($urandom);
        h_a_address[h*32 +: 32] = $urandom;
        h_a_data[h*64 +: 64]  = {$urandom, $urandom};
        h_a_mask[h*8 +: 8]    = 8'($urandom);
    endtask

    task automatic set_d(input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src);
        m_d_valid   = v;
        m_d_opcode  = op;
        m_d_size    = sz;
        m_d_source  = src;
        m_d_param   = 3'($urandom);
        m_d_data    = {$urandom, $urandom};
        m_d_corrupt = 1'($urandom);
    endtask

    initial begin
        int di;
        logic [3:0] exp_src [4];
        logic [3:0] bsrc;
        exp_src[0] = 4'b0101; exp_src[1] = 4'b1010;
        exp_src[2] = 4'b0101; exp_src[3] = 4'b1010;

        rst_ni = 1'b1;
        h_a_valid = '0; h_a_opcode = '0; h_a_param = '0; h_a_size = '0;
        h_a_source = '0; h_a_address = '0; h_a_data = '0; h_a_mask = '0;
        h_d_ready = 2'b11; m_a_ready = 1'b1;
        set_d(1'b0, ACK, 3'd3, 4'd0);
        model_reset();
        #2 rst_ni = 1'b0;
        @(negedge clk);

        // Reset, nothing valid: no valid or ready anywhere.
        eval();
        chk("rst_h_a_ready", h_a_ready, 2'b00);
        chk("rst_m_a_valid", m_a_valid, 1'b0);
        chk("rst_h_d_valid", h_d_valid, 2'b00);
        chk("rst_m_d_ready", m_d_ready, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // Round-robin alternation of single-beat Gets.
        h_d_ready = 2'b00;
        set_host(0, 1'b1, GET, 3'd3, 3'd5);
        set_host(1, 1'b1, GET, 3'd3, 3'd2);
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("alt_src", m_a_source, exp_src[k]);
            @(negedge clk);
        end
        eval();
        chk("alt_full", m_a_valid, 1'b0);
        @(negedge clk);
        h_a_valid = 2'b00;
        h_d_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            set_d(1'b1, ACK, 3'd3, {1'(k / 2), 3'd0});
            tick();
        end
        m_d_valid = 1'b0;

        // Put burst holds host 0 for four beats, then host 1.
        set_host(0, 1'b1, PUTFULL, 3'd5, 3'd1);
        set_host(1, 1'b1, GET, 3'd3, 3'd3);
        for (int k = 0; k < 5; k++) begin
            eval();
            chk("burst_grant", m_a_source[3], (k == 4) ? 1'b1 : 1'b0);
            @(negedge clk);
            set_host(0, 1'b1, PUTFULL, 3'd5, 3'd1);
        end
        h_a_valid = 2'b00;
        set_d(1'b1, ACK, 3'd3, 4'b0001); tick();
        set_d(1'b1, ACK, 3'd3, 4'b1011); tick();
        m_d_valid = 1'b0;

        // Outstanding limit on host 0.
        set_host(0, 1'b1, GET, 3'd2, 3'd4);
        tick(); tick();
        eval();
        chk("limit_stall", h_a_ready, 2'b00);
        @(negedge clk);
        set_host(1, 1'b1, GET, 3'd2, 3'd6);
        eval();
        chk("limit_other", h_a_ready, 2'b10);
        @(negedge clk);
        h_a_valid[1] = 1'b0;
        set_d(1'b1, ACK, 3'd3, 4'b0100);
        eval();
        chk("limit_ack_cycle", h_a_ready, 2'b00);
        @(negedge clk);
        m_d_valid = 1'b0;
        eval();
        chk("limit_release", h_a_ready, 2'b01);
        @(negedge clk);

        // Fill host 1 to its limit, then an 8-beat AccessAckData for it.
        h_a_valid = 2'b00;
        set_host(1, 1'b1, GET, 3'd6, 3'd2);
        tick();
        bsrc = 4'b1010;
        for (int k = 0; k < 9; k++) begin
            set_d(1'b1, ACKDATA, 3'd6, bsrc);
            h_d_ready = (k == 3) ? 2'b01 : 2'b11;
            eval();
            chk("dburst_valid", h_d_valid, 2'b10);
            chk("dburst_src", h_d_source, 3'b010);
            chk("dburst_rdy", m_d_ready, (k == 3) ? 1'b0 : 1'b1);
            chk("dburst_hold", h_a_ready, 2'b00);
            @(negedge clk);
        end
        m_d_valid = 1'b0;
        h_d_ready = 2'b11;
        eval();
        chk("dburst_freed", h_a_ready, 2'b10);
        @(negedge clk);

        // Reset in the middle of a Put burst.
        h_a_valid = 2'b00;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        set_host(0, 1'b1, PUTFULL, 3'd5, 3'd0);
        tick(); tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        set_host(0, 1'b1, GET, 3'd3, 3'd1);
        set_host(1, 1'b1, GET, 3'd3, 3'd1);
        eval();
        chk("rst_first_grant", m_a_source[3], 1'b0);
        chk("rst_first_ready", h_a_ready, 2'b01);
        @(negedge clk);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_ni = ($urandom_range(0, 499) != 0);
            for (int h = 0; h < 2; h++)
                set_host(h, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 2)),
                         3'($urandom_range(0, 6)), 3'($urandom));
            m_a_ready = ($urandom_range(0, 3) != 0);
            h_d_ready = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
            if (m_dleft > 0) begin
                m_d_valid = ($urandom_range(0, 3) != 0);
                m_d_data  = {$urandom, $urandom};
            end else begin
                if (m_out[0] > 0 && m_out[1] > 0) di = $urandom_range(0, 1);
                else if (m_out[0] > 0) di = 0;
                else if (m_out[1] > 0) di = 1;
                else di = -1;
                if (di < 0) m_d_valid = 1'b0;
                else set_d(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 1)),
                           3'($urandom_range(0, 6)), {1'(di), 3'($urandom)});
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tl_host_arb2.md
Name: tl_host_arb2

Overview:
- Two-host TileLink-UH arbiter sitting directly upstream of the SRAM controller's A/D channels; e.g. host 0 = instruction fetch, host 1 = data port.
- Merges both hosts' A channels onto one downstream A channel. Round-robin arbitration, with lock-out for multi-beat Put bursts.
- Tags each request's source with the host index. Routes D-channel responses back by that tag.
- Enforces a per-host outstanding-transaction limit, so the downstream queue cannot be monopolised.

Parameters:
- ADDR_WIDTH, 32, address width on all A channels
- DATA_WIDTH, 64, data width; fixed at 64 (8-byte beats)
- SOURCE_WIDTH, 4, downstream source width; each host uses SOURCE_WIDTH-1 bits
- MAX_OUTSTANDING, 2, max in-flight transactions per host (1..15)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset
- h_a_valid / h_a_ready  input / output  2  per-host A handshake; bit i = host i
- h_a_opcode, h_a_param, h_a_size  input  2x3 each  per-host A header fields, packed {h1,h0}
- h_a_source  input  2x(SOURCE_WIDTH-1)  per-host source ID
- h_a_address  input  2xADDR_WIDTH  per-host byte address
- h_a_data / h_a_mask  input  2x64 / 2x8  per-host write beat and byte mask
- h_d_valid / h_d_ready  output / input  2  per-host D handshake
- h_d_opcode, h_d_param, h_d_size  output  3 each  D header fields, broadcast to both hosts
- h_d_source  output  SOURCE_WIDTH-1  response source with the host tag stripped
- h_d_data / h_d_corrupt  output  64 / 1  broadcast response data and corrupt flag
- m_a_valid / m_a_ready  output / input  1  downstream A handshake
- m_a_opcode, m_a_param, m_a_size  output  3 each  granted host's header fields
- m_a_source  output  SOURCE_WIDTH  {grant, host source}
- m_a_address / m_a_data / m_a_mask  output  ADDR_WIDTH / 64 / 8  granted host's payload
- m_d_valid / m_d_ready  input / output  1  downstream D handshake
- m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_data, m_d_corrupt  input  per TL-UH  downstream response

Behaviour:
- Reset rst_ni, asynchronous, active-low; clock clk_i.
- Registered state cleared on reset:
  - lock = 0
  - lock_host = 0
  - a_beats_rem = 0
  - last_grant = 1, so host 0 wins first
  - out_cnt[0..1] = 0
  - d_beats_rem = 0
- All outputs are combinational from inputs and state. With no valids asserted, every valid and ready output is 0.
- Zero-cycle A path and D path; the block inserts no pipeline registers.
- Eligibility, unlocked:
  - elig[i] = h_a_valid[i] && (out_cnt[i] < MAX_OUTSTANDING).
  - grant = the only eligible host if exactly one; if both are eligible, !last_grant.
- Eligibility, locked: grant = lock_host, and the out_cnt check is bypassed for continuation beats.
- A mux:
  - m_a_valid = granted host's valid (masked by elig when unlocked). Payload comes from the granted host.
  - h_a_ready[grant] = m_a_ready; the other host's ready is 0.
- A-beat accept = m_a_valid && m_a_ready.
- Header accept (accept while unlocked):
  - last_grant <= grant.
  - out_cnt[grant] increments.
  - If opcode is PutFull (1) or PutPartial (2) and size > 3: lock <= 1, lock_host <= grant, a_beats_rem <= 2^(size-3) - 1.
- Continuation accept (accept while locked): a_beats_rem decrements. When it was 1, lock <= 0 in the same edge.
- Get never locks: it is a single A beat regardless of size.
- D routing:
  - idx = m_d_source[SOURCE_WIDTH-1].
  - h_d_valid[idx] = m_d_valid; the other host's h_d_valid = 0.
  - m_d_ready = h_d_ready[idx].
  - h_d_source = m_d_source[SOURCE_WIDTH-2:0]; all other fields are broadcast.
- D burst tracking, on each D beat accept (m_d_valid && h_d_ready[idx]):
  - If d_beats_rem == 0 and the response is AccessAckData (1) with size > 3: d_beats_rem <= 2^(size-3) - 1. Otherwise the beat is the last beat.
  - If d_beats_rem > 0: decrement; the beat is last when d_beats_rem was 1.
- The last D beat decrements out_cnt[idx]. A simultaneous increment and decrement on the same host leaves the count unchanged.
- Corrupt responses (size, alignment or range errors) are routed and counted identically to good responses.
- Counter widths:
  - a_beats_rem and d_beats_rem: 4 bits (size 7 gives 16 beats).
  - out_cnt: 4 bits; saturation is a bench assertion, never reached by design.
- Reset mid-burst returns to the initial state. Downstream is reset in the same domain, so no partial burst survives.

Decomposition:
- tl_pkg holds:
  - the opcode constants GET = 0, PUTFULL = 1, PUTPART = 2, ACK = 0, ACKDATA = 1
  - function tl_beats(size), returning 1 if size <= 3, else 2^(size-3)
- One sub-module: tl_burst_cnt, loadable down-counter with load/dec/last outputs. It is instantiated twice: once for the A-channel lock, once for D-burst tracking.

Test Plan:
- Both hosts assert a Get (size 3) every cycle, m_a_ready = 1 → grants alternate 0,1,0,1. m_a_source = {0,src0} then {1,src1}.
- Host 0 PutFull size 5 (4 beats) while host 1 holds valid Get → 4 consecutive host-0 beats on m_a, then host 1 is granted on the 5th beat.
- MAX_OUTSTANDING = 2, host 0 issues 3 Gets with d_ready low → third Get stalls with h_a_ready[0] = 0 while host 1 proceeds. One AccessAck for host 0 → third Get is accepted the next cycle.
- D AccessAckData size 6 (8 beats), source 4'b1010 → 8 beats appear on h_d_valid[1] with h_d_source = 3'b010. out_cnt[1] decrements only on beat 8.
- h_d_ready[1] = 0 during a D beat for host 1 → m_d_ready = 0. Host 0's h_d_valid stays 0 throughout.
- rst_ni low after beat 2 of a 4-beat Put → lock and counters clear. After release, host 0 is granted first.
